// File: rtl/heap_pkg.sv
// Shared definitions for the heap loader slice.
// Holds the heap mode codes, the bank select codes, the bank count, the loader
// FSM state type and a helper that returns the lowest enabled bank of a mask.
package heap_pkg;

    // Heap operating mode driven on SRAM_State.
    typedef enum logic [1:0] {
        ST_STATIC  = 2'b00,
        ST_OFFCHIP = 2'b01,
        ST_RUN     = 2'b10
    } sram_state_t;

    // Bank select codes. The code of an enabled bank equals its seg_mask bit index.
    typedef enum logic [2:0] {
        SEL_X    = 3'b000,
        SEL_W    = 3'b001,
        SEL_WIN  = 3'b010,
        SEL_WINB = 3'b011,
        SEL_WOUT = 3'b100,
        SEL_NONE = 3'b111
    } sel_t;

    localparam int unsigned BANK_COUNT = 5;

    typedef logic [BANK_COUNT-1:0] bank_mask_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } load_state_t;

    // Lowest enabled bank index; returns 0 for an empty mask (caller guards that case).
    function automatic logic [2:0] first_bank(input bank_mask_t mask);
        logic [2:0] b;
        logic       found;
        b     = 3'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < BANK_COUNT; i++) begin
            if (!found && mask[i]) begin
                b     = 3'(i);
                found = 1'b1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/heap_loader_if.sv
// Stream and heap write-port bundle for heap_loader.
//   s_valid / s_ready / s_data       : incoming word stream (valid/ready)
//   SRAM_State                       : heap mode (00 static, 01 off-chip write)
//   SEL_inSRAM_offchip               : bank select, 111 = no write
//   addr_inSRAM_offchip, Data_offchip: write address and data
// master: the loader side (consumes the stream, drives the heap write port).
// slave : the environment side (produces the stream, observes the heap port).
interface heap_loader_if #(
    parameter int addr_length = 10,
    parameter int bit_length  = 32
);
    logic                   s_valid;
    logic                   s_ready;
    logic [bit_length-1:0]  s_data;
    logic [1:0]             SRAM_State;
    logic [2:0]             SEL_inSRAM_offchip;
    logic [addr_length-1:0] addr_inSRAM_offchip;
    logic [bit_length-1:0]  Data_offchip;

    modport master (
        input  s_valid, s_data,
        output s_ready, SRAM_State, SEL_inSRAM_offchip, addr_inSRAM_offchip, Data_offchip
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, SRAM_State, SEL_inSRAM_offchip, addr_inSRAM_offchip, Data_offchip
    );
endinterface

// File: rtl/heap_bank_picker.sv
// Combinational next-enabled-bank finder.
//   mask      : bank enables, bit0 = X .. bit4 = Wout
//   cur       : current bank index
//   next_bank : lowest enabled bank above cur (equals cur when none remains)
//   none_left : no enabled bank above cur
module heap_bank_picker
    import heap_pkg::*;
(
    input  bank_mask_t  mask,
    input  logic [2:0]  cur,
    output logic [2:0]  next_bank,
    output logic        none_left
);

    always_comb begin
        next_bank = cur;
        none_left = 1'b1;
        for (int unsigned i = 0; i < BANK_COUNT; i++) begin
            if (none_left && (i > 32'(cur)) && mask[i]) begin
                next_bank = 3'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/heap_loader.sv
// Fills the heap banks (X, W, Win, Winb, Wout) from a valid/ready word stream.
// Each accepted word becomes one heap write cycle with select, address and data
// presented together on the following cycle. Enabled banks are filled in order,
// node_num words each, then the heap is returned to static mode and done pulses.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load request, sampled only when idle
//   abort      : cancel an in-progress load (no done pulse)
//   seg_mask   : bank enables, sampled with start
//   bus        : stream input and heap write port (heap_loader_if.master)
//   busy       : high while loading
//   done       : one-cycle pulse at load completion
module heap_loader
    import heap_pkg::*;
#(
    parameter int addr_length = 10,
    parameter int bit_length  = 32,
    parameter int node_num    = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4:0]           seg_mask,
    heap_loader_if.master        bus,
    output logic                 busy,
    output logic                 done
);

    if (longint'(node_num) > (longint'(1) << addr_length)) begin : g_node_num_check
        $error("heap_loader: node_num does not fit in addr_length address bits");
    end

    localparam logic [addr_length-1:0] LAST_ADDR = addr_length'(node_num - 1);

    load_state_t            state_q, state_d;
    bank_mask_t             mask_q, mask_d;
    logic [2:0]             bank_q, bank_d;
    logic [addr_length-1:0] cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic                   ready_q, ready_d;
    sram_state_t            sram_q, sram_d;
    logic [2:0]             sel_q, sel_d;
    logic [addr_length-1:0] addr_q, addr_d;
    logic [bit_length-1:0]  data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [2:0]             pick_next;
    logic                   none_left;
    logic                   beat;

    heap_bank_picker u_picker (
        .mask      (mask_q),
        .cur       (bank_q),
        .next_bank (pick_next),
        .none_left (none_left)
    );

    // abort masks ready combinationally so a word offered alongside it is never taken.
    assign bus.s_ready = ready_q & ~abort;
    assign beat        = bus.s_valid & bus.s_ready;

    // The *_d values are the registered outputs for the next cycle, so every
    // output below is a flop. last_q marks the drain cycle after the final
    // beat: ready is already low and the final write is on the port.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ready_d = 1'b0;
        sram_d  = ST_STATIC;
        sel_d   = SEL_NONE;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (seg_mask != '0) begin
                        state_d = S_LOAD;
                        mask_d  = seg_mask;
                        bank_d  = first_bank(seg_mask);
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        ready_d = 1'b1;
                        sram_d  = ST_OFFCHIP;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    data_d  = '0;
                end else if (last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    sram_d  = ST_OFFCHIP;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    if (beat) begin
                        sel_d  = bank_q;
                        addr_d = cnt_q;
                        data_d = bus.s_data;
                        if (cnt_q == LAST_ADDR) begin
                            cnt_d = '0;
                            if (none_left) begin
                                last_d  = 1'b1;
                                ready_d = 1'b0;
                            end else begin
                                bank_d = pick_next;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            bank_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            sram_q  <= ST_STATIC;
            sel_q   <= SEL_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            sram_q  <= sram_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.SRAM_State          = sram_q;
    assign bus.SEL_inSRAM_offchip  = sel_q;
    assign bus.addr_inSRAM_offchip = addr_q;
    assign bus.Data_offchip        = data_q;
    assign busy                    = busy_q;
    assign done                    = done_q;

endmodule

// File: tb/tb_heap_loader.sv
// Self-checking bench for heap_loader with node_num = 4.
// Table of load scenarios plus hand-written abort and reset sequences; heap
// writes are checked against an expected-write queue filled before each load.
module tb_heap_loader;

    localparam int AL   = 10;
    localparam int BL   = 32;
    localparam int NODE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] seg_mask;
    logic       busy;
    logic       done;

    heap_loader_if #(.addr_length(AL), .bit_length(BL)) bus ();

    heap_loader #(.addr_length(AL), .bit_length(BL), .node_num(NODE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .seg_mask (seg_mask),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    sel;
        logic [AL-1:0] addr;
        logic [BL-1:0] data;
    } wr_t;

    typedef struct {
        logic [4:0] mask;
        bit         toggle;
        int         exp_acc;
        int         exp_done;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];
    int   tests = 0;
    int   fails = 0;
    int   word  = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sram"},  64'(bus.SRAM_State), 64'(2'b00));
        check({tag, "_sel"},   64'(bus.SEL_inSRAM_offchip), 64'(3'b111));
        check({tag, "_addr"},  64'(bus.addr_inSRAM_offchip), 64'd0);
        check({tag, "_data"},  64'(bus.Data_offchip), 64'd0);
        check({tag, "_ready"}, 64'(bus.s_ready), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
    endtask

    // Expected writes for a full load of mask, data continuing from word.
    task automatic push_expected(input logic [4:0] mask);
        int k;
        k = 0;
        for (int b = 0; b < 5; b++) begin
            if (mask[b]) begin
                for (int a = 0; a < NODE; a++) begin
                    exp_q.push_back('{sel: 3'(b), addr: AL'(a), data: BL'(word + k)});
                    k++;
                end
            end
        end
    endtask

    // Starts a load and streams words until done (bounded). restart_cyc >= 0
    // raises start with a different mask mid-load, which must be ignored.
    task automatic run_load(input logic [4:0] mask, input bit toggle, input int restart_cyc,
                            output int acc, output int done_cyc);
        int cyc;
        acc      = 0;
        done_cyc = -1;
        start    = 1'b1;
        seg_mask = mask;
        bus.s_valid = 1'b0;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 200 && done_cyc < 0) begin
            if (done) done_cyc = cyc;
            if (cyc == restart_cyc) begin
                start    = 1'b1;
                seg_mask = 5'b11111;
            end else begin
                start = 1'b0;
            end
            bus.s_valid = toggle ? cyc[0] : 1'b1;
            bus.s_data  = BL'(word);
            #1;
            if (bus.s_valid && bus.s_ready) begin
                acc++;
                word++;
            end
            tick();
            cyc++;
        end
        start       = 1'b0;
        bus.s_valid = 1'b0;
    endtask

    // Write monitor: each heap write pops one expected entry; idle port invariants.
    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            if (bus.SEL_inSRAM_offchip != 3'b111) begin
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_sram", 64'(bus.SRAM_State), 64'(2'b01));
                    check("write_sel",  64'(bus.SEL_inSRAM_offchip), 64'(e.sel));
                    check("write_addr", 64'(bus.addr_inSRAM_offchip), 64'(e.addr));
                    check("write_data", 64'(bus.Data_offchip), 64'(e.data));
                end
            end
            if (busy) begin
                check("busy_sram", 64'(bus.SRAM_State), 64'(2'b01));
            end else begin
                check("idle_port", 64'({bus.SRAM_State, bus.SEL_inSRAM_offchip, bus.s_ready}),
                      64'({2'b00, 3'b111, 1'b0}));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        int done_cyc;

        vecs[0] = '{mask: 5'b11111, toggle: 1'b0, exp_acc: 20, exp_done: 22};
        vecs[1] = '{mask: 5'b00101, toggle: 1'b1, exp_acc: 8,  exp_done: 17};
        vecs[2] = '{mask: 5'b00000, toggle: 1'b0, exp_acc: 0,  exp_done: 1};
        vecs[3] = '{mask: 5'b10010, toggle: 1'b1, exp_acc: 8,  exp_done: 17};
        vecs[4] = '{mask: 5'b01000, toggle: 1'b0, exp_acc: 4,  exp_done: 6};

        rst = 1'b1; start = 1'b0; abort = 1'b0; seg_mask = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            push_expected(vecs[i].mask);
            run_load(vecs[i].mask, vecs[i].toggle, -1, acc, done_cyc);
            check($sformatf("vec%0d_accepts", i), 64'(acc), 64'(vecs[i].exp_acc));
            check($sformatf("vec%0d_done_cycle", i), 64'(done_cyc), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_writes_left", i), 64'(exp_q.size()), 64'd0);
            tick();
        end

        // Abort after 3 beats into W: 4 X writes + 3 W writes, nothing more.
        for (int k = 0; k < 7; k++)
            exp_q.push_back('{sel: (k < 4) ? 3'd0 : 3'd1, addr: AL'(k % 4), data: BL'(word + k)});
        start = 1'b1; seg_mask = 5'b11111;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = BL'(word);
            #1;
            check("abort_pre_ready", 64'(bus.s_ready), 64'd1);
            word++;
            tick();
        end
        abort = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = BL'(32'hdead_beef);
        #1;
        check("abort_ready_masked", 64'(bus.s_ready), 64'd0);
        tick();
        abort = 1'b0;
        bus.s_valid = 1'b0;
        check_idle("abort");
        check("abort_writes_left", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", 64'(done), 64'd0);
        end
        push_expected(5'b00001);
        run_load(5'b00001, 1'b0, -1, acc, done_cyc);
        check("restart_accepts", 64'(acc), 64'd4);
        check("restart_done_cycle", 64'(done_cyc), 64'd6);
        check("restart_writes_left", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset mid-load (5 beats in), then a load with start pulsed during busy.
        push_expected(5'b11111);
        start = 1'b1; seg_mask = 5'b11111;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = BL'(word);
            word++;
            tick();
        end
        rst = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = BL'(word);
        tick();
        rst = 1'b0;
        bus.s_valid = 1'b0;
        check_idle("midrst");
        check("midrst_writes_seen", 64'(exp_q.size()), 64'd15);
        exp_q.delete();
        tick();
        push_expected(5'b00110);
        run_load(5'b00110, 1'b0, 3, acc, done_cyc);
        check("busystart_accepts", 64'(acc), 64'd8);
        check("busystart_done_cycle", 64'(done_cyc), 64'd10);
        check("busystart_writes_left", 64'(exp_q.size()), 64'd0);
        tick();
        check("busystart_idle_busy", 64'(busy), 64'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/heap_loader.md
Name: heap_loader

Overview:
- Off-chip-side initiator that fills the SRAM heap (X, W, Win, Winb, Wout banks) from a valid/ready word stream.
- Each accepted word becomes one heap write cycle: SRAM_State=01, bank select, address, data, all driven together.
- It sequences through the enabled banks in a fixed order, then hands the heap back idle (SRAM_State=00) and pulses done.
- Sits between the off-chip interface and the heap's write port; the compute controller takes over after done.

Parameters:
- addr_length, 10, heap address width
- bit_length, 32, data word width
- node_num, 1000, words per bank; addresses run 0..node_num-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle load request; sampled only in IDLE
- abort  in  1  cancel an in-progress load
- seg_mask  in  5  bank enables, bit0=X(sel 000) .. bit4=Wout(sel 100); sampled at start
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word ready
- s_data  in  bit_length  stream word
- SRAM_State  out  2  heap mode: 00 static, 01 off-chip write
- SEL_inSRAM_offchip  out  3  bank select; 111 = no write
- addr_inSRAM_offchip  out  addr_length  write address
- Data_offchip  out  bit_length  write data
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse when the load completes

Behaviour:
- All outputs are registered. Reset values: SRAM_State=00, SEL=111, addr=0, Data=0, s_ready=0, busy=0, done=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - start=1 with seg_mask!=0: latch mask, select lowest enabled bank, addr counter=0, go to LOAD.
  - start=1 with seg_mask==0: go directly to DONE.
- LOAD:
  - s_ready=1 and busy=1. SRAM_State=01 every cycle.
  - Beat accepted (s_valid & s_ready): next cycle SEL=current bank code, addr=counter, Data=s_data, all in the same cycle. The heap adds its own one-cycle delay to both address and data, so the loader must not skew them.
  - No beat: next cycle SEL=111, Data holds its last value. The heap performs no write for SEL=111, so bubbles are safe.
  - After a beat at counter=node_num-1: counter wraps to 0 and the bank advances to the next enabled bank in order X, W, Win, Winb, Wout. Disabled banks are skipped in zero cycles.
  - If no enabled bank remains, go to DONE. s_ready drops in the cycle after the final beat; no extra word is accepted.
- DONE (one cycle):
  - SRAM_State=00, SEL=111, s_ready=0, done=1. The final write beat is already on the outputs the cycle before.
  - Next state is IDLE.
- abort in LOAD: next cycle returns to IDLE with outputs at reset values and no done pulse. A beat presented in the same cycle as abort is not accepted (s_ready is combinationally masked by abort).
- start in LOAD or DONE is ignored.
- rst in any state takes precedence over everything, including mid-load. Partially written heap contents are not undone.
- Address arithmetic is unsigned at addr_length bits. node_num <= 2^addr_length is required (checked by an elaboration-time assertion).
- Throughput: one word per cycle with continuous s_valid. A full 5-bank load takes 5*node_num beats + 2 cycles from start to done.

Decomposition:
- Shared package heap_pkg:
  - SRAM_State codes (ST_STATIC=00, ST_OFFCHIP=01, ST_RUN=10)
  - bank select codes SEL_X..SEL_WOUT, SEL_NONE=111
  - bank count 5
- Sub-module heap_bank_picker: combinational next-enabled-bank finder. Takes mask and current bank; returns next bank and a none_left flag.
- FSM, address counter, and output registers stay in heap_loader.

Test Plan:
- node_num=4, seg_mask=11111, continuous s_valid, data=0..19 -> 20 writes: SEL 000 addr 0-3 data 0-3, then 001 addr 0-3, ... 100 addr 0-3 data 16-19; done 2 cycles after the last accept.
- seg_mask=00101, s_valid toggling 1/0 -> only SEL 000 and 010 appear; SEL=111 and SRAM_State=01 on every bubble cycle; 8 writes total.
- seg_mask=00000 with start -> done one cycle later; SRAM_State never leaves 00; s_ready never high.
- abort asserted after 3 beats into W -> next cycle SRAM_State=00, SEL=111, busy=0, no done; a following start restarts at X addr 0.
- rst pulsed mid-load, then start during busy -> all outputs return to reset values; start during busy has no effect on bank or address.
- Back-pressure check: s_valid held high through DONE -> exactly 5*node_num words accepted; s_ready=0 from the cycle after the last beat.
